// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the power-on / reset sequencer.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    POR,
    STAGE,
    RUN
  } seq_state_e;

  localparam logic [7:0] LOST_CNT_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == LOST_CNT_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the sequencer and the board top level.
interface reset_sequencer_if #(
  parameter int N_CHAN = 2
);

  logic              locked;
  logic              soft_rst_req;
  logic [N_CHAN-1:0] rst_out;
  logic              ready;
  logic [7:0]        lock_lost_cnt;

  modport master (
    output locked,
    output soft_rst_req,
    input  rst_out,
    input  ready,
    input  lock_lost_cnt
  );

  modport slave (
    input  locked,
    input  soft_rst_req,
    output rst_out,
    output ready,
    output lock_lost_cnt
  );

endinterface

// File: rtl/reset_sequencer_lock_qualifier.sv
// Synchronises an asynchronous status bit and qualifies it after a run of
// consecutive high samples; any low sample drops the qualification at once.
module reset_sequencer_lock_qualifier #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_ok
);

  localparam int FW = $clog2(LOCK_FILTER) + 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [FW-1:0]          r_filt_cnt;
  logic                   r_ok;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !w_sync) begin
      r_filt_cnt <= '0;
      r_ok       <= 1'b0;
    end else if (!r_ok) begin
      if (r_filt_cnt == FW'(LOCK_FILTER - 1)) begin
        r_ok <= 1'b1;
      end else begin
        r_filt_cnt <= r_filt_cnt + FW'(1);
      end
    end
  end

  // Loss is unfiltered: a low synchronised sample kills o_ok in that cycle.
  assign o_ok = r_ok & w_sync;

endmodule

// File: rtl/reset_sequencer.sv
// Power-on reset sequencer: waits for qualified PLL lock, holds a POR delay,
// then releases the reset domains one at a time, lowest index first.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int N_CHAN       = 2,
  parameter int POR_CYCLES   = 1023,
  parameter int STAGE_CYCLES = 16,
  parameter int LOCK_FILTER  = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic             clk,
  input  logic             rst,
  reset_sequencer_if.slave bus
);

  localparam int PW = $clog2(POR_CYCLES) + 1;
  localparam int SW = $clog2(STAGE_CYCLES) + 1;
  localparam int IW = $clog2(N_CHAN) + 1;

  logic              w_lock_ok;

  seq_state_e        r_state,     w_state_nxt;
  logic [PW-1:0]     r_por_cnt,   w_por_cnt_nxt;
  logic [SW-1:0]     r_stage_cnt, w_stage_cnt_nxt;
  logic [IW-1:0]     r_stage_idx, w_stage_idx_nxt;
  logic [N_CHAN-1:0] r_rst_out,   w_rst_out_nxt;
  logic              r_ready,     w_ready_nxt;
  logic [7:0]        r_lost_cnt,  w_lost_cnt_nxt;

  reset_sequencer_lock_qualifier #(
    .SYNC_STAGES (SYNC_STAGES),
    .LOCK_FILTER (LOCK_FILTER)
  ) u_lock_qualifier (
    .clk     (clk),
    .rst     (rst),
    .i_async (bus.locked),
    .o_ok    (w_lock_ok)
  );

  // NOTE: every next-state variable gets a default first, so no path infers a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_por_cnt_nxt   = r_por_cnt;
    w_stage_cnt_nxt = r_stage_cnt;
    w_stage_idx_nxt = r_stage_idx;
    w_rst_out_nxt   = r_rst_out;
    w_ready_nxt     = r_ready;
    w_lost_cnt_nxt  = r_lost_cnt;

    // Lock loss outranks a simultaneous software request.
    if (r_state != WAIT_LOCK && !w_lock_ok) begin
      w_state_nxt    = WAIT_LOCK;
      w_rst_out_nxt  = '1;
      w_ready_nxt    = 1'b0;
      w_lost_cnt_nxt = sat_inc(r_lost_cnt);
    end else if (r_state != WAIT_LOCK && bus.soft_rst_req) begin
      w_state_nxt   = POR;
      w_por_cnt_nxt = '0;
      w_rst_out_nxt = '1;
      w_ready_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        WAIT_LOCK: begin
          w_rst_out_nxt = '1;
          w_ready_nxt   = 1'b0;
          if (w_lock_ok) begin
            w_state_nxt   = POR;
            w_por_cnt_nxt = '0;
          end
        end
        POR: begin
          if (r_por_cnt == PW'(POR_CYCLES - 1)) begin
            w_rst_out_nxt[0] = 1'b0;
            if (N_CHAN == 1) begin
              w_state_nxt = RUN;
              w_ready_nxt = 1'b1;
            end else begin
              w_state_nxt     = STAGE;
              w_stage_idx_nxt = IW'(1);
              w_stage_cnt_nxt = '0;
            end
          end else begin
            w_por_cnt_nxt = r_por_cnt + PW'(1);
          end
        end
        STAGE: begin
          if (r_stage_cnt == SW'(STAGE_CYCLES - 1)) begin
            w_rst_out_nxt   = r_rst_out & ~(N_CHAN'(1) << r_stage_idx);
            w_stage_cnt_nxt = '0;
            if (r_stage_idx == IW'(N_CHAN - 1)) begin
              w_state_nxt = RUN;
              w_ready_nxt = 1'b1;
            end else begin
              w_stage_idx_nxt = r_stage_idx + IW'(1);
            end
          end else begin
            w_stage_cnt_nxt = r_stage_cnt + SW'(1);
          end
        end
        RUN: begin
          w_rst_out_nxt = '0;
          w_ready_nxt   = 1'b1;
        end
        default: begin
          w_state_nxt = WAIT_LOCK;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= WAIT_LOCK;
      r_por_cnt   <= '0;
      r_stage_cnt <= '0;
      r_stage_idx <= '0;
      r_rst_out   <= '1;
      r_ready     <= 1'b0;
      r_lost_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_por_cnt   <= w_por_cnt_nxt;
      r_stage_cnt <= w_stage_cnt_nxt;
      r_stage_idx <= w_stage_idx_nxt;
      r_rst_out   <= w_rst_out_nxt;
      r_ready     <= w_ready_nxt;
      r_lost_cnt  <= w_lost_cnt_nxt;
    end
  end

  assign bus.rst_out       = r_rst_out;
  assign bus.ready         = r_ready;
  assign bus.lock_lost_cnt = r_lost_cnt;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with N_CHAN=3, POR=4, STAGE=3, FILTER=2, SYNC=2.
module tb_reset_sequencer;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;

  reset_sequencer_if #(.N_CHAN(N)) bus ();

  reset_sequencer #(
    .N_CHAN       (N),
    .POR_CYCLES   (4),
    .STAGE_CYCLES (3),
    .LOCK_FILTER  (2),
    .SYNC_STAGES  (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] e_rst, input logic e_rdy);
    check({tag, ".rst_out"}, 32'(bus.rst_out), 32'(e_rst));
    check({tag, ".ready"}, 32'(bus.ready), 32'(e_rdy));
    check({tag, ".cnt"}, 32'(bus.lock_lost_cnt), 32'(exp_cnt));
  endtask

  // Caller has just set locked=1; the next rising edge is edge 0.
  task automatic run_sequence(input string tag);
    step(8);
    check_outs({tag, "@e7"}, 3'b111, 1'b0);
    step(1);
    check_outs({tag, "@e8"}, 3'b110, 1'b0);
    step(2);
    check_outs({tag, "@e10"}, 3'b110, 1'b0);
    step(1);
    check_outs({tag, "@e11"}, 3'b100, 1'b0);
    step(2);
    check_outs({tag, "@e13"}, 3'b100, 1'b0);
    step(1);
    check_outs({tag, "@e14"}, 3'b000, 1'b1);
  endtask

  initial begin
    bus.locked       = 1'b0;
    bus.soft_rst_req = 1'b0;

    // Reset state
    step(3);
    check_outs("reset", 3'b111, 1'b0);
    rst = 1'b0;

    // Single-cycle lock glitch never qualifies
    step(2);
    bus.locked = 1'b1;
    step(1);
    bus.locked = 1'b0;
    step(6);
    check_outs("glitch", 3'b111, 1'b0);

    // Cold start
    bus.locked = 1'b1;
    run_sequence("cold");
    step(2);
    check_outs("run_hold", 3'b000, 1'b1);

    // Lock loss in RUN: visible on the third edge after the drop
    bus.locked = 1'b0;
    step(2);
    check_outs("loss_e1", 3'b000, 1'b1);
    step(1);
    exp_cnt = 1;
    check_outs("loss_e2", 3'b111, 1'b0);
    bus.locked = 1'b1;
    run_sequence("relock");

    // Soft request in RUN, then again one cycle after rst_out[0] falls
    bus.soft_rst_req = 1'b1;
    step(1);
    bus.soft_rst_req = 1'b0;
    check_outs("soft_run", 3'b111, 1'b0);
    step(3);
    check_outs("soft_run_por", 3'b111, 1'b0);
    step(1);
    check_outs("soft_run_rel", 3'b110, 1'b0);
    bus.soft_rst_req = 1'b1;
    step(1);
    bus.soft_rst_req = 1'b0;
    check_outs("soft_stage", 3'b111, 1'b0);
    step(2);
    bus.soft_rst_req = 1'b1;
    step(1);
    bus.soft_rst_req = 1'b0;
    check_outs("soft_por", 3'b111, 1'b0);
    step(3);
    check_outs("soft_por_hold", 3'b111, 1'b0);
    step(1);
    check_outs("soft_por_rel", 3'b110, 1'b0);
    step(3);
    check_outs("soft_stage1", 3'b100, 1'b0);
    step(3);
    check_outs("soft_done", 3'b000, 1'b1);

    // Simultaneous lock loss and soft request: lock loss wins
    bus.locked = 1'b0;
    step(2);
    bus.soft_rst_req = 1'b1;
    step(1);
    bus.soft_rst_req = 1'b0;
    exp_cnt = 2;
    check_outs("both", 3'b111, 1'b0);
    step(4);
    check_outs("both_no_rel", 3'b111, 1'b0);
    bus.locked = 1'b1;
    run_sequence("both_relock");

    // Saturation of lock_lost_cnt
    bus.locked = 1'b0;
    step(3);
    exp_cnt = 3;
    check_outs("sat_first", 3'b111, 1'b0);
    for (int i = 0; i < 257; i++) begin
      bus.locked = 1'b1;
      step(6);
      bus.locked = 1'b0;
      step(4);
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      if (exp_cnt >= 254) check_outs("sat_loop", 3'b111, 1'b0);
    end
    check_outs("sat_final", 3'b111, 1'b0);

    // rst mid-sequence clears everything
    bus.locked = 1'b1;
    step(7);
    rst = 1'b1;
    step(1);
    exp_cnt = 0;
    check_outs("rst_mid", 3'b111, 1'b0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Parametrised power-on/reset sequencer that replaces the ad-hoc POR delay counter in board top levels. It synchronises and filters the PLL lock signal, holds off for a programmable POR delay, then releases N reset domains in a staggered order. It re-enters reset automatically if lock is lost or software requests a reset. It sits between the PLL primitive and all downstream blocks (vga, future peripherals) in the PLL output clock domain.

Parameters:
N_CHAN, 2, number of reset outputs (domains), >=1
POR_CYCLES, 1023, cycles held in reset after lock is qualified, >=1
STAGE_CYCLES, 16, cycles between consecutive domain releases, >=1
LOCK_FILTER, 8, consecutive synchronised-high cycles needed to qualify lock, >=1
SYNC_STAGES, 2, flops in the lock synchroniser, >=2

Ports:
clk  in  1  PLL output clock; everything runs on its rising edge
rst  in  1  synchronous, active-high reset
locked  in  1  raw PLL lock, asynchronous to clk
soft_rst_req  in  1  single-cycle synchronous request to re-run the sequence
rst_out  out  N_CHAN  per-domain active-high reset; bit 0 released first
ready  out  1  high when all domains are released
lock_lost_cnt  out  8  saturating count of lock-loss events since rst

Behaviour:
- One clock; reset is synchronous and active-high, ports named clk and rst.
- Under rst: rst_out all ones, ready 0, lock_lost_cnt 0, synchroniser flops 0, filter/POR/stage counters 0, state WAIT_LOCK.
- locked passes through a SYNC_STAGES flop chain giving lock_s. lock_ok is set after lock_s has been 1 for LOCK_FILTER consecutive cycles. Any lock_s=0 clears lock_ok and the filter count in the same cycle. Loss is not filtered.
- FSM states:
  - WAIT_LOCK: rst_out all 1. Move to POR when lock_ok=1.
  - POR: count POR_CYCLES cycles. On terminal count, go to STAGE, clear rst_out[0], stage index=1.
  - STAGE: every STAGE_CYCLES cycles clear rst_out[stage index] and increment it. When rst_out[N_CHAN-1] clears, go to RUN. If N_CHAN=1, POR goes directly to RUN.
  - RUN: rst_out all 0, ready 1.
- All outputs are registered. ready rises in the same cycle rst_out[N_CHAN-1] falls.
- Contract latency: the first edge sampling locked=1 (held) to rst_out[0] low is SYNC_STAGES+LOCK_FILTER+POR_CYCLES cycles. rst_out[k] falls STAGE_CYCLES*k cycles after rst_out[0].
- Lock loss (lock_ok falling) in POR, STAGE or RUN:
  - next cycle: rst_out all 1, ready 0, state WAIT_LOCK;
  - lock_lost_cnt increments once per event and saturates at 255.
- Lock loss in WAIT_LOCK (filter not yet qualified) does not count.
- soft_rst_req=1 in POR, STAGE or RUN with lock_ok=1:
  - next cycle: rst_out all 1, ready 0, state POR with a fresh count;
  - a request during POR restarts the count.
- soft_rst_req is ignored in WAIT_LOCK.
- Simultaneous lock loss and soft_rst_req: lock loss wins (WAIT_LOCK, counter increments).
- rst asserted mid-sequence returns everything to reset values on the next edge, regardless of state.
- Counter widths: $clog2 of the maximum terminal value plus 1. No wrap is possible.

Decomposition:
- Shared package: FSM state enum (WAIT_LOCK, POR, STAGE, RUN) and the lock_lost_cnt saturation constant (8'hFF).
- One natural sub-module: lock_qualifier (synchroniser plus consecutive-high filter, outputs lock_ok). It can be reused for other async status inputs.

Test Plan:
All scenarios use N_CHAN=3, POR_CYCLES=4, STAGE_CYCLES=3, LOCK_FILTER=2, SYNC_STAGES=2, unless stated.
1. Cold start: rst for 3 cycles, then locked=1 at edge 0 -> rst_out[0] low at edge 8, rst_out[1] at 11, rst_out[2] and ready at 14; rst_out=3'b111 before edge 8.
2. Lock glitch before qualification: locked pulses 1 for a single cycle -> lock_s high 1 cycle, lock_ok never sets, rst_out stays 3'b111, lock_lost_cnt=0.
3. Lock loss in RUN: after ready, drop locked -> 2 cycles later lock_s=0; next edge rst_out=3'b111, ready=0, lock_lost_cnt=1. Relock -> full sequence repeats with the same 8/11/14 timing.
4. soft_rst_req in STAGE, one cycle after rst_out[0] falls -> rst_out=3'b111 next cycle; rst_out[0] falls 4 cycles later; lock_lost_cnt unchanged.
5. soft_rst_req and lock loss in the same cycle -> state WAIT_LOCK (no release after 4 cycles, even with locked restored late), lock_lost_cnt increments by 1.
6. Saturation: force 260 lock-loss events -> lock_lost_cnt=255. Then rst -> lock_lost_cnt=0, rst_out=3'b111, ready=0.
